// File: rtl/lms_step_controller.sv
// Variable-step-size controller for an LMS adaptive filter.
// Squares the filter error, averages it over fixed windows to estimate MSE,
// and steps a three-state convergence FSM that selects the filter step size.
module lms_step_controller #(
  parameter int unsigned             WIDTH        = 16,
  parameter int unsigned             FRAC         = 15,
  parameter int unsigned             WINDOW_LOG2  = 4,
  parameter logic [WIDTH-1:0]        MU_MAX       = 16'd3276,
  parameter logic [WIDTH-1:0]        MU_MIN       = 16'd328,
  parameter logic [WIDTH-1:0]        CONV_THRESH  = 16'd256,
  parameter logic [WIDTH-1:0]        REACQ_THRESH = 16'd1024,
  parameter logic [WIDTH-1:0]        DIV_THRESH   = 16'd16384,
  parameter int unsigned             CONV_WINDOWS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] error,
  input  logic             restart,
  output logic [WIDTH-1:0] step_size,
  output logic [WIDTH-1:0] mse,
  output logic             mse_valid,
  output logic [1:0]       state,
  output logic             converged,
  output logic             diverged
);

  localparam int unsigned AccW  = WIDTH + WINDOW_LOG2;
  localparam int unsigned ConvW = $clog2(CONV_WINDOWS + 1);

  typedef enum logic [1:0] {
    StAcquire  = 2'd0,
    StTrack    = 2'd1,
    StDiverged = 2'd2
  } state_e;

  state_e                   state_q, state_d;
  logic [WIDTH-1:0]         step_q, step_d;
  logic [WIDTH-1:0]         mse_q, mse_d;
  logic                     mse_valid_q, mse_valid_d;
  logic [AccW-1:0]          acc_q, acc_d;
  logic [WINDOW_LOG2-1:0]   cnt_q, cnt_d;
  logic [ConvW-1:0]         conv_q, conv_d;

  logic signed [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0]        prod_shr;
  logic [WIDTH-1:0]          sq;
  logic [AccW-1:0]           acc_sum;
  logic [ConvW-1:0]          conv_inc;

  // Square the error in Q1.15; only (-1)*(-1) overflows and is clamped.
  always_comb begin
    prod     = $signed(error) * $signed(error);
    prod_shr = prod >> FRAC;
    sq       = prod_shr[WIDTH-1:0];
    if (|prod_shr[2*WIDTH-1:WIDTH-1]) begin
      sq = {1'b0, {(WIDTH-1){1'b1}}};
    end
    acc_sum  = acc_q + {{WINDOW_LOG2{1'b0}}, sq};
    conv_inc = conv_q + 1'b1;
  end

  // Window accumulation, MSE capture and convergence FSM next state.
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    mse_d       = mse_q;
    mse_valid_d = 1'b0;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    conv_d      = conv_q;

    if (restart) begin
      // The sample presented alongside restart is dropped.
      acc_d   = '0;
      cnt_d   = '0;
      conv_d  = '0;
      state_d = StAcquire;
    end else begin
      if (en) begin
        if (cnt_q == '1) begin
          mse_d       = acc_sum[AccW-1:WINDOW_LOG2];
          mse_valid_d = 1'b1;
          acc_d       = '0;
          cnt_d       = '0;
        end else begin
          acc_d = acc_sum;
          cnt_d = cnt_q + 1'b1;
        end
      end

      if (mse_valid_q) begin
        if (mse_q >= DIV_THRESH) begin
          state_d = StDiverged;
          conv_d  = '0;
        end else begin
          unique case (state_q)
            StAcquire: begin
              if (mse_q < CONV_THRESH) begin
                if (conv_inc == ConvW'(CONV_WINDOWS)) begin
                  state_d = StTrack;
                  conv_d  = '0;
                end else begin
                  conv_d = conv_inc;
                end
              end else begin
                conv_d = '0;
              end
            end
            StTrack: begin
              if (mse_q >= REACQ_THRESH) begin
                state_d = StAcquire;
                conv_d  = '0;
              end
            end
            default: state_d = StDiverged;
          endcase
        end
      end
    end

    // Step size is registered so it moves on the same edge as the state.
    unique case (state_d)
      StAcquire: step_d = MU_MAX;
      StTrack:   step_d = MU_MIN;
      default:   step_d = '0;
    endcase
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StAcquire;
      step_q      <= MU_MAX;
      mse_q       <= '0;
      mse_valid_q <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      conv_q      <= '0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      mse_q       <= mse_d;
      mse_valid_q <= mse_valid_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      conv_q      <= conv_d;
    end
  end

  assign step_size = step_q;
  assign mse       = mse_q;
  assign mse_valid = mse_valid_q;
  assign state     = state_q;
  assign converged = (state_q == StTrack);
  assign diverged  = (state_q == StDiverged);

endmodule

// File: tb/tb_lms_step_controller.sv
// Directed self-checking bench for lms_step_controller.
module tb_lms_step_controller;

  logic        clk;
  logic        rst;
  logic        en;
  logic [15:0] error;
  logic        restart;
  logic [15:0] step_size;
  logic [15:0] mse;
  logic        mse_valid;
  logic [1:0]  state;
  logic        converged;
  logic        diverged;

  int n_checks = 0;
  int n_errors = 0;

  lms_step_controller dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .error     (error),
    .restart   (restart),
    .step_size (step_size),
    .mse       (mse),
    .mse_valid (mse_valid),
    .state     (state),
    .converged (converged),
    .diverged  (diverged)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive n consecutive en-samples, then drop en at the following negedge.
  task automatic feed(input logic [15:0] e, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      en    = 1'b1;
      error = e;
    end
    @(negedge clk);
    en = 1'b0;
  endtask

  // Full window; checks the MSE pulse, then advances to where the FSM has updated.
  task automatic window(input string tag, input logic [15:0] e, input logic [15:0] exp_mse);
    feed(e, 16);
    check_eq({tag, " mse_valid"}, 32'(mse_valid), 32'd1);
    check_eq({tag, " mse"}, 32'(mse), 32'(exp_mse));
    @(negedge clk);
  endtask

  task automatic check_state(input string tag, input logic [1:0] st, input logic [15:0] step);
    check_eq({tag, " state"}, 32'(state), 32'(st));
    check_eq({tag, " step"}, 32'(step_size), 32'(step));
    check_eq({tag, " converged"}, 32'(converged), 32'(st == 2'd1));
    check_eq({tag, " diverged"}, 32'(diverged), 32'(st == 2'd2));
  endtask

  task automatic pulse_restart();
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; en = 1'b0; error = '0; restart = 1'b0;
    repeat (2) @(negedge clk);
    check_state("reset", 2'd0, 16'd3276);
    check_eq("reset mse", 32'(mse), 32'd0);
    check_eq("reset mse_valid", 32'(mse_valid), 32'd0);
    rst = 1'b0;

    // Convergence: four windows of mse=128; TRACK exactly two edges after the last sample.
    window("conv w1", 16'h0800, 16'd128);
    window("conv w2", 16'h0800, 16'd128);
    window("conv w3", 16'h0800, 16'd128);
    check_state("conv pre", 2'd0, 16'd3276);
    feed(16'h0800, 16);
    check_eq("conv w4 mse_valid", 32'(mse_valid), 32'd1);
    check_eq("conv w4 state E+1", 32'(state), 32'd0);
    @(negedge clk);
    check_state("conv track", 2'd1, 16'd328);
    check_eq("conv pulse one-cycle", 32'(mse_valid), 32'd0);

    // Re-acquire, then a 512 window breaks the converged run.
    window("reacq", 16'h2000, 16'd2048);
    check_state("reacq acq", 2'd0, 16'd3276);
    window("reacq a1", 16'h0800, 16'd128);
    window("reacq a2", 16'h0800, 16'd128);
    window("reacq a3", 16'h0800, 16'd128);
    window("reacq mid", 16'h1000, 16'd512);
    check_state("reacq after 512", 2'd0, 16'd3276);
    window("reacq b1", 16'h0800, 16'd128);
    window("reacq b2", 16'h0800, 16'd128);
    window("reacq b3", 16'h0800, 16'd128);
    check_state("reacq b3", 2'd0, 16'd3276);
    window("reacq b4", 16'h0800, 16'd128);
    check_state("reacq track", 2'd1, 16'd328);

    // Divergence: saturated square, sticky until restart.
    window("div", 16'h8000, 16'd32767);
    check_state("div", 2'd2, 16'd0);
    window("div sticky", 16'h0800, 16'd128);
    check_state("div sticky", 2'd2, 16'd0);
    pulse_restart();
    check_state("div restart", 2'd0, 16'd3276);
    check_eq("div restart mse held", 32'(mse), 32'd128);
    feed(16'h0800, 15);
    check_eq("div post 15", 32'(mse_valid), 32'd0);
    feed(16'h0800, 1);
    check_eq("div post 16 valid", 32'(mse_valid), 32'd1);
    check_eq("div post 16 mse", 32'(mse), 32'd128);

    // en every other cycle: mse_valid only after the 16th enabled sample.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      en    = 1'b1;
      error = 16'h0800;
      @(negedge clk);
      en = 1'b0;
      if (i < 15) check_eq("gap no valid", 32'(mse_valid), 32'd0);
      else        check_eq("gap valid", 32'(mse_valid), 32'd1);
    end
    check_eq("gap mse", 32'(mse), 32'd128);
    @(negedge clk);

    // restart on the window-end sample: no pulse, conv count and sample count cleared.
    feed(16'h0800, 15);
    @(negedge clk);
    en = 1'b1; error = 16'h0800; restart = 1'b1;
    @(negedge clk);
    en = 1'b0; restart = 1'b0;
    check_eq("rvw no valid", 32'(mse_valid), 32'd0);
    @(negedge clk);
    check_eq("rvw no valid late", 32'(mse_valid), 32'd0);
    feed(16'h0800, 15);
    check_eq("rvw counter cleared", 32'(mse_valid), 32'd0);
    feed(16'h0800, 1);
    check_eq("rvw w1 valid", 32'(mse_valid), 32'd1);
    @(negedge clk);
    window("rvw w2", 16'h0800, 16'd128);
    window("rvw w3", 16'h0800, 16'd128);
    check_state("rvw conv cleared", 2'd0, 16'd3276);
    window("rvw w4", 16'h0800, 16'd128);
    check_state("rvw track", 2'd1, 16'd328);

    // Asynchronous reset mid-window, observed before the next clock edge.
    feed(16'h2000, 5);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_state("async rst", 2'd0, 16'd3276);
    check_eq("async rst mse", 32'(mse), 32'd0);
    check_eq("async rst mse_valid", 32'(mse_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    feed(16'h0800, 15);
    check_eq("post rst 15", 32'(mse_valid), 32'd0);
    feed(16'h0800, 1);
    check_eq("post rst valid", 32'(mse_valid), 32'd1);
    check_eq("post rst mse", 32'(mse), 32'd128);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
